// File: rtl/pin_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pin_pkg                                                       |
// | Purpose  : Shared pin geometry, fixed-point types, rack table and the    |
// |            pin_motion FSM state enum. Imported by pin_motion, the        |
// |            collision detector and the renderer.                          |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package pin_pkg;

  localparam int NUM_PINS       = 10;
  localparam int SCREEN_WIDTH   = 1024;
  localparam int SCREEN_HEIGHT  = 768;
  localparam int FRAC_BITS      = 4;
  localparam int FRICTION_SHIFT = 3;

  localparam int VEL_W  = 16;
  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int X_FP_W = X_W + FRAC_BITS;
  localparam int Y_FP_W = Y_W + FRAC_BITS;

  // Wide enough for either axis; the y axis keeps only its low Y_FP_W bits.
  typedef logic        [X_FP_W-1:0] pos_fp_t;
  typedef logic signed [VEL_W-1:0]  vel_t;
  typedef logic        [X_W-1:0]    pix_x_t;
  typedef logic        [Y_W-1:0]    pix_y_t;

  // Triangle rack: head pin first, then rows of 2, 3 and 4 pins.
  localparam pix_x_t PIN_RACK_X [NUM_PINS] = '{
    11'd512,
    11'd500, 11'd524,
    11'd488, 11'd512, 11'd536,
    11'd476, 11'd500, 11'd524, 11'd548
  };
  localparam pix_y_t PIN_RACK_Y [NUM_PINS] = '{
    10'd200,
    10'd220, 10'd220,
    10'd240, 10'd240, 10'd240,
    10'd260, 10'd260, 10'd260, 10'd260
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } pin_motion_state_e;

endpackage
`default_nettype wire

// File: rtl/pin_axis_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pin_axis_step                                                 |
// | Purpose  : Combinational one-axis integrator: position += velocity,      |
// |            bound check against BOUND pixels, optional friction decay.    |
// | Ports    : i_pos (unsigned fixed point), i_vel (signed Q11.4) ->         |
// |            o_pos, o_vel, o_out_of_bounds                                 |
// | Config   : PIN_MOTION_FRICTION_EN enables per-frame velocity decay       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pin_axis_step
  import pin_pkg::*;
#(
  parameter int POS_W = X_FP_W,
  parameter int BOUND = SCREEN_WIDTH
) (
  input  logic [POS_W-1:0] i_pos,
  input  vel_t             i_vel,
  output logic [POS_W-1:0] o_pos,
  output vel_t             o_vel,
  output logic             o_out_of_bounds
);

  // One bit wider than the wider operand so the signed sum cannot wrap.
  localparam int c_sum_w = ((POS_W + 1 > VEL_W) ? POS_W + 1 : VEL_W) + 1;
  localparam logic signed [c_sum_w-1:0] c_limit = c_sum_w'(BOUND << FRAC_BITS);

  logic signed [c_sum_w-1:0] w_pos_ext;
  logic signed [c_sum_w-1:0] w_vel_ext;
  logic signed [c_sum_w-1:0] w_sum;
  vel_t                      w_vel_next;

`ifdef PIN_MOTION_FRICTION_EN
  localparam vel_t c_stop = vel_t'(1 << FRICTION_SHIFT);
  vel_t w_decay;
`endif

  always_comb begin
    w_pos_ext       = {{(c_sum_w-POS_W){1'b0}}, i_pos};
    w_vel_ext       = {{(c_sum_w-VEL_W){i_vel[VEL_W-1]}}, i_vel};
    w_sum           = w_pos_ext + w_vel_ext;
    o_out_of_bounds = w_sum[c_sum_w-1] || (w_sum >= c_limit);
`ifdef PIN_MOTION_FRICTION_EN
    // Arithmetic shift alone never reaches zero for small positive speeds,
    // so anything below one friction quantum is snapped to rest.
    w_decay    = i_vel - (i_vel >>> FRICTION_SHIFT);
    w_vel_next = ((w_decay > -c_stop) && (w_decay < c_stop)) ? '0 : w_decay;
`else
    w_vel_next = i_vel;
`endif
    o_pos = o_out_of_bounds ? '1 : w_sum[POS_W-1:0];
    o_vel = o_out_of_bounds ? '0 : w_vel_next;
  end

endmodule
`default_nettype wire

// File: rtl/pin_motion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pin_motion                                                    |
// | Purpose  : Pin kinematics integrator. Absorbs collision velocities,      |
// |            integrates one pin per cycle on each frame tick and parks     |
// |            pins that leave the lane.                                     |
// | Ports    : clk_in, rst_n_in (async, active low), frame_in, rack_in,      |
// |            coll_done_in, pins_hit_in, pins_vx_in, pins_vy_in ->          |
// |            pins_x_out, pins_y_out, pins_down_out, pins_valid_out,        |
// |            busy_out                                                      |
// | Config   : PIN_MOTION_FRICTION_EN enables per-frame velocity decay       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pin_motion
  import pin_pkg::*;
(
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            frame_in,
  input  logic                            rack_in,
  input  logic                            coll_done_in,
  input  logic [NUM_PINS-1:0]             pins_hit_in,
  input  logic [NUM_PINS-1:0][VEL_W-1:0]  pins_vx_in,
  input  logic [NUM_PINS-1:0][VEL_W-1:0]  pins_vy_in,
  output logic [NUM_PINS-1:0][X_W-1:0]    pins_x_out,
  output logic [NUM_PINS-1:0][Y_W-1:0]    pins_y_out,
  output logic [NUM_PINS-1:0]             pins_down_out,
  output logic                            pins_valid_out,
  output logic                            busy_out
);

  localparam int                 c_idx_w    = $clog2(NUM_PINS);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_PINS - 1);

  pos_fp_t             r_pos_x [NUM_PINS];
  logic [Y_FP_W-1:0]   r_pos_y [NUM_PINS];
  vel_t                r_vel_x [NUM_PINS];
  vel_t                r_vel_y [NUM_PINS];
  vel_t                r_sh_vx [NUM_PINS];
  vel_t                r_sh_vy [NUM_PINS];
  logic [NUM_PINS-1:0] r_sh_mask;
  logic [NUM_PINS-1:0] r_down;
  logic                r_valid;
  logic                r_frame_pending;
  logic [c_idx_w-1:0]  r_idx;
  pin_motion_state_e   r_state;

  // Shadow contents including a strobe arriving this cycle, so a strobe
  // landing in DONE is applied rather than lost.
  logic [NUM_PINS-1:0] w_sh_mask;
  vel_t                w_sh_vx [NUM_PINS];
  vel_t                w_sh_vy [NUM_PINS];

  pos_fp_t             w_nxt_x;
  logic [Y_FP_W-1:0]   w_nxt_y;
  vel_t                w_nvel_x;
  vel_t                w_nvel_y;
  logic                w_oob_x;
  logic                w_oob_y;

  assign w_sh_mask = coll_done_in ? (r_sh_mask | pins_hit_in) : r_sh_mask;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    assign pins_x_out[gi] = r_pos_x[gi][X_FP_W-1:FRAC_BITS];
    assign pins_y_out[gi] = r_pos_y[gi][Y_FP_W-1:FRAC_BITS];
    // The shadow holds the latest strobe's full velocity vectors.
    assign w_sh_vx[gi]    = coll_done_in ? vel_t'(pins_vx_in[gi]) : r_sh_vx[gi];
    assign w_sh_vy[gi]    = coll_done_in ? vel_t'(pins_vy_in[gi]) : r_sh_vy[gi];
  end

  pin_axis_step #(.POS_W(X_FP_W), .BOUND(SCREEN_WIDTH)) u_step_x (
    .i_pos           (r_pos_x[r_idx]),
    .i_vel           (r_vel_x[r_idx]),
    .o_pos           (w_nxt_x),
    .o_vel           (w_nvel_x),
    .o_out_of_bounds (w_oob_x)
  );

  pin_axis_step #(.POS_W(Y_FP_W), .BOUND(SCREEN_HEIGHT)) u_step_y (
    .i_pos           (r_pos_y[r_idx]),
    .i_vel           (r_vel_y[r_idx]),
    .o_pos           (w_nxt_y),
    .o_vel           (w_nvel_y),
    .o_out_of_bounds (w_oob_y)
  );

  assign pins_down_out  = r_down;
  assign pins_valid_out = r_valid;
  assign busy_out       = (r_state != ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in || rack_in) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        r_pos_x[i] <= {PIN_RACK_X[i], FRAC_BITS'(0)};
        r_pos_y[i] <= {PIN_RACK_Y[i], FRAC_BITS'(0)};
        r_vel_x[i] <= '0;
        r_vel_y[i] <= '0;
        r_sh_vx[i] <= '0;
        r_sh_vy[i] <= '0;
      end
      r_sh_mask       <= '0;
      r_down          <= '0;
      r_valid         <= 1'b0;
      r_frame_pending <= 1'b0;
      r_idx           <= '0;
      r_state         <= ST_IDLE;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Velocities land before stepping, so a same-cycle frame uses them.
          if (coll_done_in) begin
            for (int i = 0; i < NUM_PINS; i++) begin
              if (pins_hit_in[i] && !r_down[i]) begin
                r_vel_x[i] <= vel_t'(pins_vx_in[i]);
                r_vel_y[i] <= vel_t'(pins_vy_in[i]);
              end
            end
          end
          if (frame_in || r_frame_pending) begin
            r_state         <= ST_STEP;
            r_idx           <= '0;
            r_frame_pending <= 1'b0;
          end
        end
        ST_STEP: begin
          if (coll_done_in) begin
            r_sh_mask <= w_sh_mask;
            for (int i = 0; i < NUM_PINS; i++) begin
              r_sh_vx[i] <= w_sh_vx[i];
              r_sh_vy[i] <= w_sh_vy[i];
            end
          end
          if (frame_in) r_frame_pending <= 1'b1;
          if (!r_down[r_idx]) begin
            if (w_oob_x || w_oob_y) begin
              // Park on both axes so collision ignores the pin entirely.
              r_down[r_idx]  <= 1'b1;
              r_pos_x[r_idx] <= '1;
              r_pos_y[r_idx] <= '1;
              r_vel_x[r_idx] <= '0;
              r_vel_y[r_idx] <= '0;
            end else begin
              r_pos_x[r_idx] <= w_nxt_x;
              r_pos_y[r_idx] <= w_nxt_y;
              r_vel_x[r_idx] <= w_nvel_x;
              r_vel_y[r_idx] <= w_nvel_y;
            end
          end
          if (r_idx == c_last_idx) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (frame_in) r_frame_pending <= 1'b1;
          for (int i = 0; i < NUM_PINS; i++) begin
            if (w_sh_mask[i] && !r_down[i]) begin
              r_vel_x[i] <= w_sh_vx[i];
              r_vel_y[i] <= w_sh_vy[i];
            end
          end
          r_sh_mask <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
